// File: rtl/hit_scanner.sv
// Per-frame bullet-vs-player collision scanner: walks the bullet RAM once per frame_start and reports hits.
// Optional graze detection is compiled in when HIT_SCANNER_GRAZE_EN is defined.
module hit_scanner #(
  parameter int N_BULLETS = 64,
  parameter int ADDR_W    = 6,
  parameter int COORD_W   = 10,
  parameter int HIT_R     = 3,
  parameter int GRAZE_R   = 12
) (
  input  logic                 clk,
  input  logic                 hard_reset,
  input  logic                 game_reset,
  input  logic                 game_en,
  input  logic                 frame_start,
  input  logic [COORD_W-1:0]   player_x,
  input  logic [COORD_W-1:0]   player_y,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [2*COORD_W:0]   rd_data,
  output logic                 busy,
  output logic                 collision,
  output logic [ADDR_W:0]      hit_count,
  output logic [ADDR_W-1:0]    hit_addr,
  output logic                 overrun,
  output logic                 graze
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, REPORT} state_t;

  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(N_BULLETS - 1);
  localparam logic [ADDR_W:0]    CNT_MAX   = (ADDR_W + 1)'(N_BULLETS);
  localparam logic [COORD_W:0]   HIT_LIM   = (COORD_W + 1)'(HIT_R);

  if (GRAZE_R < HIT_R || (1 << ADDR_W) < N_BULLETS) begin : g_param_check
    $error("hit_scanner: inconsistent parameters");
  end

  state_t state, state_nxt;

  logic [COORD_W-1:0] px, py;
  logic [ADDR_W:0]    acc_cnt, cnt_nxt;
  logic [ADDR_W-1:0]  acc_addr, addr_nxt, test_idx;

  logic                      b_vld;
  logic [COORD_W-1:0]        bx, by;
  logic signed [COORD_W:0]   dx, dy;
  logic [COORD_W:0]          adx, ady;
  logic                      test_en, is_hit;

  assign b_vld = rd_data[2*COORD_W];
  assign bx    = rd_data[2*COORD_W-1:COORD_W];
  assign by    = rd_data[COORD_W-1:0];

  // Zero-extended signed differences: no wrap-around at the screen edges.
  assign dx  = $signed({1'b0, bx}) - $signed({1'b0, px});
  assign dy  = $signed({1'b0, by}) - $signed({1'b0, py});
  assign adx = dx[COORD_W] ? $unsigned(-dx) : $unsigned(dx);
  assign ady = dy[COORD_W] ? $unsigned(-dy) : $unsigned(dy);

  // rd_data carries the entry for the previous cycle's address; nothing valid yet in the first SCAN cycle.
  assign test_en  = (state == SCAN && rd_addr != '0) || state == DRAIN;
  assign test_idx = (state == DRAIN) ? LAST_ADDR : rd_addr - 1'b1;
  assign is_hit   = test_en && b_vld && adx <= HIT_LIM && ady <= HIT_LIM;

  assign cnt_nxt  = acc_cnt + {{ADDR_W{1'b0}}, (is_hit && acc_cnt != CNT_MAX)};
  assign addr_nxt = (is_hit && acc_cnt == '0) ? test_idx : acc_addr;

`ifdef HIT_SCANNER_GRAZE_EN
  localparam logic [COORD_W:0] GRAZE_LIM = (COORD_W + 1)'(GRAZE_R);
  logic acc_graze, graze_nxt, graze_seen;
  assign graze_nxt = acc_graze ||
                     (test_en && b_vld && !is_hit && adx <= GRAZE_LIM && ady <= GRAZE_LIM);
  assign graze     = (state == REPORT) && graze_seen && game_en;
`else
  assign graze = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (frame_start) state_nxt = SCAN;
      SCAN:    if (rd_addr == LAST_ADDR) state_nxt = DRAIN;
      DRAIN:   state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign collision = (state == REPORT) && (hit_count != '0) && game_en;

  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      state     <= IDLE;
      rd_addr   <= '0;
      px        <= '0;
      py        <= '0;
      acc_cnt   <= '0;
      acc_addr  <= '0;
      hit_count <= '0;
      hit_addr  <= '0;
      overrun   <= 1'b0;
`ifdef HIT_SCANNER_GRAZE_EN
      acc_graze  <= 1'b0;
      graze_seen <= 1'b0;
`endif
    end else if (game_reset) begin
      state     <= IDLE;
      rd_addr   <= '0;
      px        <= '0;
      py        <= '0;
      acc_cnt   <= '0;
      acc_addr  <= '0;
      hit_count <= '0;
      hit_addr  <= '0;
      overrun   <= 1'b0;
`ifdef HIT_SCANNER_GRAZE_EN
      acc_graze  <= 1'b0;
      graze_seen <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (frame_start && busy) overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            px       <= player_x;
            py       <= player_y;
            rd_addr  <= '0;
            acc_cnt  <= '0;
            acc_addr <= '0;
`ifdef HIT_SCANNER_GRAZE_EN
            acc_graze <= 1'b0;
`endif
          end
        end
        SCAN: begin
          if (rd_addr != LAST_ADDR) rd_addr <= rd_addr + 1'b1;
          acc_cnt  <= cnt_nxt;
          acc_addr <= addr_nxt;
`ifdef HIT_SCANNER_GRAZE_EN
          acc_graze <= graze_nxt;
`endif
        end
        DRAIN: begin
          acc_cnt   <= cnt_nxt;
          acc_addr  <= addr_nxt;
          hit_count <= cnt_nxt;
          hit_addr  <= addr_nxt;
`ifdef HIT_SCANNER_GRAZE_EN
          acc_graze  <= graze_nxt;
          graze_seen <= graze_nxt;
`endif
        end
        REPORT:  rd_addr <= '0;
        default: rd_addr <= '0;
      endcase
    end
  end

endmodule
